// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline control blocks.
// Forwarding select encodings, mult/div sequencer states and register-match helper.
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hard-wired, so a write to it can never create a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Multi-cycle mult/div sequencer: tracks execute latency and pulses the HI/LO write.
// A start request is only honoured from IDLE; starts while BUSY/DONE are ignored.
module muldiv_seq
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy,
    output logic o_hilo_we
);

    // Counter preload is latency-2: one cycle is spent in IDLE accepting the start
    // and one in DONE issuing the write strobe.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_cnt_nxt   = i_is_div ? DIV_LOAD : MUL_LOAD;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_busy    = (r_state == BUSY);
    assign o_hilo_we = (r_state == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush generation,
// mult/div sequencing and a saturating stall-cycle counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs_D,
    input  logic [4:0]        rt_D,
    input  logic              uses_rs_D,
    input  logic              uses_rt_D,
    input  logic              branch_D,
    input  logic              hilo_read_D,
    input  logic              muldiv_D,
    input  logic [4:0]        rs_E,
    input  logic [4:0]        rt_E,
    input  logic [4:0]        writereg_E,
    input  logic              REGWRITE_E,
    input  logic              MEMTOREG_E,
    input  logic              muldiv_start_E,
    input  logic              is_div_E,
    input  logic [4:0]        writereg_M,
    input  logic              REGWRITE_M,
    input  logic              MEMTOREG_M,
    input  logic [4:0]        writereg_WB,
    input  logic              REGWRITE_WB,
    output logic              forwardA_D,
    output logic              forwardB_D,
    output logic [1:0]        forwardA_E,
    output logic [1:0]        forwardB_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_E,
    output logic              muldiv_busy,
    output logic              hilo_we,
    output logic [PERF_W-1:0] stall_cycles
);

    logic              w_lw_stall;
    logic              w_br_stall;
    logic              w_md_stall;
    logic              w_stall;
    logic              w_busy;
    logic              w_hilo_we;
    logic [PERF_W-1:0] r_stall_cycles;

    // Memory stage wins over writeback: it holds the younger result.
    function automatic fwd_sel_e fwd_sel(input logic [4:0] src);
        if (REGWRITE_M && reg_hit(writereg_M, src)) begin
            return FWD_MEM;
        end else if (REGWRITE_WB && reg_hit(writereg_WB, src)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    assign forwardA_E = fwd_sel(rs_E);
    assign forwardB_E = fwd_sel(rt_E);

    // A load in M has no ALU result to forward; the branch stall covers that case.
    assign forwardA_D = REGWRITE_M && !MEMTOREG_M && reg_hit(writereg_M, rs_D);
    assign forwardB_D = REGWRITE_M && !MEMTOREG_M && reg_hit(writereg_M, rt_D);

    assign w_lw_stall = MEMTOREG_E && REGWRITE_E &&
                        ((uses_rs_D && reg_hit(writereg_E, rs_D)) ||
                         (uses_rt_D && reg_hit(writereg_E, rt_D)));

    assign w_br_stall = branch_D &&
                        ((REGWRITE_E && (reg_hit(writereg_E, rs_D) || reg_hit(writereg_E, rt_D))) ||
                         (MEMTOREG_M && (reg_hit(writereg_M, rs_D) || reg_hit(writereg_M, rt_D))));

    assign w_md_stall = w_busy && (hilo_read_D || muldiv_D);

    assign w_stall = w_lw_stall || w_br_stall || w_md_stall;
    assign stall_F = w_stall;
    assign stall_D = w_stall;
    assign flush_E = w_stall;

    muldiv_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_muldiv_seq (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (muldiv_start_E),
        .i_is_div  (is_div_E),
        .o_busy    (w_busy),
        .o_hilo_we (w_hilo_we)
    );

    assign muldiv_busy = w_busy;
    assign hilo_we     = w_hilo_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {PERF_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls, mult/div sequencing and counter saturation.
module tb_hazard_ctrl;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_WB;
    logic          uses_rs_D, uses_rt_D, branch_D, hilo_read_D, muldiv_D;
    logic          REGWRITE_E, MEMTOREG_E, muldiv_start_E, is_div_E;
    logic          REGWRITE_M, MEMTOREG_M, REGWRITE_WB;
    logic          forwardA_D, forwardB_D, stall_F, stall_D, flush_E, muldiv_busy, hilo_we;
    logic [1:0]    forwardA_E, forwardB_E;
    logic [PW-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D),
        .branch_D(branch_D), .hilo_read_D(hilo_read_D), .muldiv_D(muldiv_D),
        .rs_E(rs_E), .rt_E(rt_E), .writereg_E(writereg_E),
        .REGWRITE_E(REGWRITE_E), .MEMTOREG_E(MEMTOREG_E),
        .muldiv_start_E(muldiv_start_E), .is_div_E(is_div_E),
        .writereg_M(writereg_M), .REGWRITE_M(REGWRITE_M), .MEMTOREG_M(MEMTOREG_M),
        .writereg_WB(writereg_WB), .REGWRITE_WB(REGWRITE_WB),
        .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .muldiv_busy(muldiv_busy), .hilo_we(hilo_we), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_F"}, 32'(stall_F), 32'(exp));
        chk({tag, "_D"}, 32'(stall_D), 32'(exp));
        chk({tag, "_flush"}, 32'(flush_E), 32'(exp));
    endtask

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; uses_rs_D = 0; uses_rt_D = 0; branch_D = 0;
        hilo_read_D = 0; muldiv_D = 0; rs_E = 0; rt_E = 0; writereg_E = 0;
        REGWRITE_E = 0; MEMTOREG_E = 0; muldiv_start_E = 0; is_div_E = 0;
        writereg_M = 0; REGWRITE_M = 0; MEMTOREG_M = 0; writereg_WB = 0; REGWRITE_WB = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  saw_we;
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_cnt", 32'(stall_cycles), 0);
        chk("rst_busy", 32'(muldiv_busy), 0);
        chk("rst_we", 32'(hilo_we), 0);
        chk_stall("rst_stall", 0);
        chk("rst_fwdA_E", 32'(forwardA_E), 0);

        // Forwarding priority
        REGWRITE_M = 1; writereg_M = 8; REGWRITE_WB = 1; writereg_WB = 8; rs_E = 8; rt_E = 8;
        #1;
        chk("fwdA_E_mem", 32'(forwardA_E), 32'h2);
        chk("fwdB_E_mem", 32'(forwardB_E), 32'h2);
        REGWRITE_M = 0;
        #1;
        chk("fwdA_E_wb", 32'(forwardA_E), 32'h1);
        chk("fwdB_E_wb", 32'(forwardB_E), 32'h1);
        REGWRITE_M = 1; writereg_M = 0; writereg_WB = 0; rs_E = 0; rt_E = 0;
        #1;
        chk("fwdA_E_r0", 32'(forwardA_E), 32'h0);
        chk("fwdB_E_r0", 32'(forwardB_E), 32'h0);
        clear_inputs();

        // Load-use
        tick();
        MEMTOREG_E = 1; REGWRITE_E = 1; writereg_E = 9; uses_rt_D = 1; rt_D = 9;
        #1;
        chk_stall("lw", 1);
        tick();
        chk("lw_cnt", 32'(stall_cycles), 1);
        uses_rt_D = 0;
        #1;
        chk_stall("lw_unused", 0);
        tick();
        chk("lw_cnt_hold", 32'(stall_cycles), 1);
        clear_inputs();

        // Branch dependence on E, then resolved by forwarding from M
        branch_D = 1; rs_D = 4; REGWRITE_E = 1; writereg_E = 4;
        #1;
        chk_stall("br_E", 1);
        tick();
        chk("br_cnt", 32'(stall_cycles), 2);
        REGWRITE_E = 0; writereg_E = 0; REGWRITE_M = 1; MEMTOREG_M = 0; writereg_M = 4;
        #1;
        chk_stall("br_fwd", 0);
        chk("br_fwdA_D", 32'(forwardA_D), 1);
        chk("br_fwdB_D", 32'(forwardB_D), 0);
        MEMTOREG_M = 1;
        #1;
        chk_stall("br_ldM", 1);
        chk("br_ldM_fwdA_D", 32'(forwardA_D), 0);
        clear_inputs();
        #1;

        // Multiply: start at cycle 0, MFHI held in decode
        muldiv_start_E = 1; is_div_E = 0; hilo_read_D = 1;
        #1;
        chk_stall("mul_c0", 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            muldiv_start_E = (c == 2);  // stray start while busy must be ignored
            is_div_E = (c == 2);
            #1;
            chk("mul_busy", 32'(muldiv_busy), 1);
            chk("mul_we_early", 32'(hilo_we), 0);
            chk_stall("mul_stall", 1);
        end
        tick();
        muldiv_start_E = 0; is_div_E = 0;
        #1;
        chk("mul_c4_busy", 32'(muldiv_busy), 0);
        chk("mul_c4_we", 32'(hilo_we), 1);
        chk_stall("mul_c4", 0);
        chk("mul_cnt", 32'(stall_cycles), 5);
        tick();
        chk("mul_c5_we", 32'(hilo_we), 0);
        hilo_read_D = 0;

        // Divide aborted by reset at cycle 10
        muldiv_start_E = 1; is_div_E = 1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            muldiv_start_E = 0; is_div_E = 0;
            chk("div_busy", 32'(muldiv_busy), 1);
            if (c == 10) reset = 1;
        end
        tick();
        reset = 0;
        chk("div_rst_busy", 32'(muldiv_busy), 0);
        chk("div_rst_we", 32'(hilo_we), 0);
        chk("div_rst_cnt", 32'(stall_cycles), 0);
        saw_we = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (hilo_we) saw_we = 1;
        end
        chk("div_abort_no_we", 32'(saw_we), 0);

        // Full divide latency, bounded wait
        muldiv_start_E = 1; is_div_E = 1;
        lat = 0;
        saw_we = 0;
        for (int c = 1; c <= 40 && !saw_we; c++) begin
            tick();
            muldiv_start_E = 0; is_div_E = 0;
            if (hilo_we) begin
                saw_we = 1;
                lat = c;
            end
        end
        chk("div_latency", 32'(lat), 32);

        // Counter saturation under a held load-use stall
        clear_inputs();
        chk("sat_start", 32'(stall_cycles), 0);
        MEMTOREG_E = 1; REGWRITE_E = 1; writereg_E = 9; uses_rs_D = 1; rs_D = 9;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 14) chk("sat_14", 32'(stall_cycles), 14);
            if (c == 15) chk("sat_15", 32'(stall_cycles), 15);
        end
        chk("sat_20", 32'(stall_cycles), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
